// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the single-ported data memory
// IF and D-cache paths alternate under contention; each access holds the memory for MEM_LATENCY cycles.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                if_req,
  input  logic [31:0]         if_addr,
  output logic                if_gnt,
  output logic                if_done,
  output logic [31:0]         if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [31:0]         d_addr,
  input  logic [31:0]         d_wdata,
  output logic                d_gnt,
  output logic                d_done,
  output logic [31:0]         d_rdata,
  output logic [31:0]         mem_addr,
  output logic [0:3][7:0]     mem_data_in,
  input  logic [0:3][7:0]     mem_data_out,
  output logic                mem_write_en,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_owner;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;

  logic             pick_d;
  logic             pick_if;
  logic             idle_gnt;
  logic             last_beat;
  logic [31:0]      mem_rd;

  // D wins unless IF is also asking and D had the previous grant.
  assign pick_d    = d_req && (!if_req || (last_owner == OWN_IF));
  assign pick_if   = if_req && !pick_d;
  // Grants are Mealy; gating with reset keeps them low while reset is held.
  assign idle_gnt  = !rst_b && (state == IDLE);
  assign if_gnt    = idle_gnt && pick_if;
  assign d_gnt     = idle_gnt && pick_d;
  assign last_beat = (cnt == CNT_W'(MEM_LATENCY - 1));
  assign busy      = (state != IDLE);

  assign mem_addr    = addr_q;
  assign mem_data_in = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};
  assign mem_rd      = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state        <= IDLE;
      cnt          <= '0;
      owner        <= OWN_IF;
      last_owner   <= OWN_IF;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      if_done      <= 1'b0;
      d_done       <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state      <= ACCESS;
            cnt        <= '0;
            owner      <= pick_d;
            last_owner <= pick_d;
            if (pick_d) begin
              addr_q       <= d_addr;
              wdata_q      <= d_wdata;
              we_q         <= d_we;
              mem_write_en <= d_we;
            end else begin
              addr_q       <= if_addr;
              wdata_q      <= '0;
              we_q         <= 1'b0;
              mem_write_en <= 1'b0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (last_beat) begin
            state        <= DONE;
            mem_write_en <= 1'b0;
            if_done      <= (owner == OWN_IF);
            d_done       <= (owner == OWN_D);
            // Writes leave the read-data registers untouched.
            if (!we_q) begin
              if (owner == OWN_D) d_rdata  <= mem_rd;
              else                if_rdata <= mem_rd;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          if_done <= 1'b0;
          d_done  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          if_done      <= 1'b0;
          d_done       <= 1'b0;
          mem_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Cycle table for single accesses, plus hand sequences for contention, reset and MEM_LATENCY=1.
module tb_mem_port_arbiter;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            if_req, d_req, d_we;
  logic [31:0]     if_addr, d_addr, d_wdata;
  logic [0:3][7:0] mem_data_out;

  logic            if_gnt, if_done, d_gnt, d_done, mem_write_en, busy;
  logic [31:0]     if_rdata, d_rdata, mem_addr;
  logic [0:3][7:0] mem_data_in;

  logic            if_gnt2, if_done2, d_gnt2, d_done2, mem_write_en2, busy2;
  logic [31:0]     if_rdata2, d_rdata2, mem_addr2;
  logic [0:3][7:0] mem_data_in2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2), .if_done(if_done2), .if_rdata(if_rdata2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_done(d_done2), .d_rdata(d_rdata2),
    .mem_addr(mem_addr2), .mem_data_in(mem_data_in2), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en2), .busy(busy2)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [31:0] mdo;
    logic [5:0]  fl;   // {if_gnt, d_gnt, if_done, d_done, mem_write_en, busy}
    logic [31:0] ma;
    logic [31:0] mdi;
    logic        cm;   // mem_data_in is only meaningful while D owns the latch
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic ifr, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                     input logic [31:0] mdo, input logic [5:0] fl, input logic [31:0] ma,
                     input logic [31:0] mdi, input logic cm, input logic [31:0] ird,
                     input logic [31:0] drd);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.mdo = mdo;
    v.fl = fl; v.ma = ma; v.mdi = mdi; v.cm = cm; v.ird = ird; v.drd = drd;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags1();
    return {if_gnt, d_gnt, if_done, d_done, mem_write_en, busy};
  endfunction

  localparam logic [31:0] M1 = 32'h78563412;
  localparam logic [31:0] M2 = 32'h11223344;
  localparam logic [31:0] M3 = 32'hA0B0C0D0;
  localparam logic [31:0] I1 = 32'h12345678;
  localparam logic [31:0] D1 = 32'h44332211;
  localparam logic [31:0] I2 = 32'hD0C0B0A0;
  localparam logic [31:0] WB = 32'hEFBEADDE;
  localparam logic [31:0] W2 = 32'h04030201;

  initial begin
    logic [5:0] ef;
    int         bad_cnt;

    rst_b = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h100; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; mem_data_out = M1;

    // Table: IF read, D write, D read, IF arriving mid-D-access.
    add(1, 1, 32'h100, 0, 0, 0, 0, M1, 6'b100000, 0, 0, 1, 0, 0);
    add(4, 0, 32'h100, 0, 0, 0, 0, M1, 6'b000001, 32'h100, 0, 0, 0, 0);
    add(1, 0, 32'h100, 0, 0, 0, 0, M1, 6'b001001, 32'h100, 0, 0, I1, 0);
    add(1, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF, M1, 6'b010000, 32'h100, 0, 0, I1, 0);
    add(4, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF, M1, 6'b000011, 32'h40, WB, 1, I1, 0);
    add(1, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF, M1, 6'b000101, 32'h40, WB, 1, I1, 0);
    add(1, 0, 0, 1, 0, 32'h80, 0, M2, 6'b010000, 32'h40, WB, 1, I1, 0);
    add(4, 0, 0, 0, 0, 32'h80, 0, M2, 6'b000001, 32'h80, 0, 1, I1, 0);
    add(1, 0, 0, 0, 0, 32'h80, 0, M2, 6'b000101, 32'h80, 0, 1, I1, D1);
    add(1, 0, 0, 1, 1, 32'h44, 32'h01020304, M2, 6'b010000, 32'h80, 0, 1, I1, D1);
    add(1, 0, 0, 0, 1, 32'h44, 32'h01020304, M2, 6'b000011, 32'h44, W2, 1, I1, D1);
    add(3, 1, 32'h200, 0, 1, 32'h44, 32'h01020304, M2, 6'b000011, 32'h44, W2, 1, I1, D1);
    add(1, 1, 32'h200, 0, 1, 32'h44, 32'h01020304, M2, 6'b000101, 32'h44, W2, 1, I1, D1);
    add(1, 1, 32'h200, 0, 1, 32'h44, 32'h01020304, M2, 6'b100000, 32'h44, W2, 1, I1, D1);
    add(4, 0, 32'h200, 0, 0, 0, 0, M3, 6'b000001, 32'h200, 0, 0, I1, D1);
    add(1, 0, 32'h200, 0, 0, 0, 0, M3, 6'b001001, 32'h200, 0, 0, I2, D1);
    add(1, 0, 32'h200, 0, 0, 0, 0, M3, 6'b000000, 32'h200, 0, 0, I2, D1);

    // Reset state, with both requests asserted to show grants stay low.
    begin_cycle();
    @(negedge clk);
    check("reset_state", {154'd0, flags1()}, 160'd0);
    check("reset_regs", {if_rdata, d_rdata, mem_addr, 32'(mem_data_in), 32'd0},
          {32'd0, 32'd0, 32'd0, 32'd0, 32'd0});

    for (int i = 0; i < vq.size(); i++) begin
      begin_cycle();
      if (i == 0) rst_b = 1'b0;
      if_req = vq[i].ifr; if_addr = vq[i].ia; d_req = vq[i].dr; d_we = vq[i].dw;
      d_addr = vq[i].da; d_wdata = vq[i].dwd; mem_data_out = vq[i].mdo;
      @(negedge clk);
      check($sformatf("row%0d", i),
            {flags1(), mem_addr, vq[i].cm ? 32'(mem_data_in) : 32'd0, if_rdata, d_rdata, 26'd0},
            {vq[i].fl, vq[i].ma, vq[i].cm ? vq[i].mdi : 32'd0, vq[i].ird, vq[i].drd, 26'd0});
    end

    // Continuous contention from reset: D, IF, D, IF, six cycles apart.
    begin_cycle();
    rst_b = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h300; d_addr = 32'h400;
    @(negedge clk);
    check("contend_in_reset", {158'd0, if_gnt, d_gnt}, 160'd0);
    for (int c = 0; c < 24; c++) begin
      begin_cycle();
      if (c == 0) rst_b = 1'b0;
      @(negedge clk);
      ef = {(c % 12) == 6, (c % 12) == 0, (c % 12) == 11, (c % 12) == 5, 1'b0, (c % 6) != 0};
      check($sformatf("contend_c%0d", c), {154'd0, flags1()}, {154'd0, ef});
    end
    begin_cycle();
    if_req = 1'b0; d_req = 1'b0;

    // Asynchronous reset in the middle of a D write.
    begin_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_wr_gnt", {154'd0, flags1()}, {154'd0, 6'b010000});
    begin_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check("rst_wr_access", {122'd0, flags1(), mem_addr}, {122'd0, 6'b000011, 32'h60});
    begin_cycle();
    #2 rst_b = 1'b1;
    #1;
    check("rst_async", {90'd0, flags1(), mem_addr, 32'(mem_data_in)}, 160'd0);
    begin_cycle();
    rst_b = 1'b0;
    bad_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (d_done || busy || mem_write_en) bad_cnt++;
      begin_cycle();
    end
    check("rst_no_done", 160'(bad_cnt), 160'd0);
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    @(negedge clk);
    check("rst_first_contend", {158'd0, if_gnt, d_gnt}, {158'd0, 2'b01});
    begin_cycle();
    if_req = 1'b0; d_req = 1'b0;
    repeat (7) begin_cycle();

    // MEM_LATENCY = 1: gnt at 0, one ACCESS cycle, done at 2.
    rst_b = 1'b1;
    begin_cycle();
    rst_b = 1'b0; if_req = 1'b1; if_addr = 32'h300; mem_data_out = M1;
    @(negedge clk);
    check("lat1_gnt", {156'd0, if_gnt2, d_gnt2, if_done2, busy2}, {156'd0, 4'b1000});
    begin_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("lat1_access", {123'd0, if_gnt2, if_done2, mem_write_en2, busy2, mem_addr2},
          {123'd0, 4'b0001, 32'h300});
    begin_cycle();
    @(negedge clk);
    check("lat1_done", {126'd0, if_done2, busy2, if_rdata2}, {126'd0, 2'b11, I1});
    begin_cycle();
    @(negedge clk);
    check("lat1_idle", {158'd0, if_done2, busy2}, 160'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
